// File: rtl/vga_pkg.sv
// Shared definitions for the sprite compositor: default 640x480 timing,
// the RGB332 pixel type, the colour key and the per-sprite config record.
package vga_pkg;

    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_START  = 144;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_TOTAL  = 521;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_START  = 31;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_CLK_DIV  = 4;

    typedef logic [7:0] rgb332_t;

    localparam rgb332_t TRANSPARENT_KEY = 8'hFF;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       vis;
    } spr_cfg_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider, raster counters and raw sync/active/frame-start decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_START  = VGA_H_START,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_TOTAL  = VGA_V_TOTAL,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_START  = VGA_V_START,
    parameter int V_ACTIVE = VGA_V_ACTIVE
) (
    input  logic       clk,
    input  logic       rst,
    output logic       o_pix_en,
    output logic [9:0] o_hcount,
    output logic [9:0] o_vcount,
    output logic       o_hs_raw,
    output logic       o_vs_raw,
    output logic       o_active,
    output logic       o_frame_start
);

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO   = 10'(H_START);
    localparam logic [9:0] H_ACT_HI   = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] V_ACT_LO   = 10'(V_START);
    localparam logic [9:0] V_ACT_HI   = 10'(V_START + V_ACTIVE);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hcount;
    logic [9:0]       r_vcount;
    logic             w_pix_en;

    // CLK_DIV is a power of two, so the divider simply wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_pix_en = &r_div;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_pix_en) begin
            if (r_hcount == H_LAST) begin
                r_hcount <= '0;
                r_vcount <= (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
        end
    end

    assign o_pix_en      = w_pix_en;
    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_hs_raw      = (r_hcount >= H_SYNC_END);
    assign o_vs_raw      = (r_vcount >= V_SYNC_END);
    assign o_active      = (r_hcount >= H_ACT_LO) && (r_hcount < H_ACT_HI) &&
                           (r_vcount >= V_ACT_LO) && (r_vcount < V_ACT_HI);
    assign o_frame_start = w_pix_en && (r_hcount == 10'd0) && (r_vcount == 10'd0);

endmodule

// File: rtl/vga_sprite_compositor.sv
// Two-stage sprite compositor over an external background, with
// frame-synchronous double-buffered sprite config and player collision flags.
module vga_sprite_compositor
    import vga_pkg::*;
#(
    parameter int NUM_SPRITES = 7,
    parameter int SPR_SIZE    = 16,
    parameter int COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] TRANSPARENT = TRANSPARENT_KEY,
    parameter int CLK_DIV     = VGA_CLK_DIV,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_START     = VGA_H_START,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_START     = VGA_V_START,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    localparam int IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int ADDR_W     = $clog2(SPR_SIZE * SPR_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [IDX_W-1:0]               cfg_idx,
    input  logic [9:0]                     cfg_x,
    input  logic [9:0]                     cfg_y,
    input  logic                           cfg_vis,
    output logic [9:0]                     hcount,
    output logic [9:0]                     vcount,
    input  logic [COLOR_W-1:0]             bg_rgb,
    output logic [NUM_SPRITES*ADDR_W-1:0]  spr_addr,
    input  logic [NUM_SPRITES*COLOR_W-1:0] spr_data,
    output logic                           hs,
    output logic                           vs,
    output logic [COLOR_W-1:0]             rgb,
    output logic                           frame_start,
    output logic [NUM_SPRITES-1:0]         collide
);

    localparam int         SZ_W       = $clog2(SPR_SIZE);
    localparam logic [9:0] SPR_SIZE_V = 10'(SPR_SIZE);

    logic       w_pix_en;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic       w_active;
    logic       w_frame_start;
    logic [9:0] w_hcount;
    logic [9:0] w_vcount;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_TOTAL  (H_TOTAL),
        .H_SYNC   (H_SYNC),
        .H_START  (H_START),
        .H_ACTIVE (H_ACTIVE),
        .V_TOTAL  (V_TOTAL),
        .V_SYNC   (V_SYNC),
        .V_START  (V_START),
        .V_ACTIVE (V_ACTIVE)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .o_pix_en      (w_pix_en),
        .o_hcount      (w_hcount),
        .o_vcount      (w_vcount),
        .o_hs_raw      (w_hs_raw),
        .o_vs_raw      (w_vs_raw),
        .o_active      (w_active),
        .o_frame_start (w_frame_start)
    );

    spr_cfg_t                      w_cfg_new;
    logic [NUM_SPRITES-1:0]        w_hit;
    logic [NUM_SPRITES*ADDR_W-1:0] w_addr;
    logic [NUM_SPRITES-1:0]        w_opaque;
    logic [NUM_SPRITES-1:0]        w_coll;
    logic [COLOR_W-1:0]            w_pix;

    logic [NUM_SPRITES-1:0]        r_hit;
    logic [NUM_SPRITES*ADDR_W-1:0] r_addr;
    logic                          r_active;
    logic                          r_hs1;
    logic                          r_vs1;
    logic [COLOR_W-1:0]            r_rgb;
    logic                          r_hs2;
    logic                          r_vs2;
    logic [NUM_SPRITES-1:0]        r_accum;
    logic [NUM_SPRITES-1:0]        r_collide;

    assign w_cfg_new = {cfg_x, cfg_y, cfg_vis};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
            spr_cfg_t    r_pend;
            spr_cfg_t    r_act;
            logic        w_wr;
            logic [10:0] w_dx;
            logic [10:0] w_dy;
            logic        w_in_x;
            logic        w_in_y;

            // Out-of-range indices never match any sprite and are dropped.
            assign w_wr = cfg_we && (cfg_idx == IDX_W'(gi));

            // A write landing on the frame-start clk goes straight to the active copy.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pend <= '0;
                    r_act  <= '0;
                end else begin
                    if (w_wr) begin
                        r_pend <= w_cfg_new;
                    end
                    if (w_frame_start) begin
                        r_act <= w_wr ? w_cfg_new : r_pend;
                    end
                end
            end

            // 11-bit difference: bit 10 set means the raster is left of / above the sprite.
            assign w_dx   = {1'b0, w_hcount} - {1'b0, r_act.x};
            assign w_dy   = {1'b0, w_vcount} - {1'b0, r_act.y};
            assign w_in_x = !w_dx[10] && (w_dx[9:0] < SPR_SIZE_V);
            assign w_in_y = !w_dy[10] && (w_dy[9:0] < SPR_SIZE_V);

            assign w_hit[gi] = r_act.vis && w_in_x && w_in_y;
            assign w_addr[gi*ADDR_W +: ADDR_W] =
                w_hit[gi] ? {w_dy[SZ_W-1:0], w_dx[SZ_W-1:0]} : '0;

            assign w_opaque[gi] = r_hit[gi] &&
                (spr_data[gi*COLOR_W +: COLOR_W] != TRANSPARENT);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit    <= '0;
            r_addr   <= '0;
            r_active <= 1'b0;
            r_hs1    <= 1'b1;
            r_vs1    <= 1'b1;
        end else if (w_pix_en) begin
            r_hit    <= w_hit;
            r_addr   <= w_addr;
            r_active <= w_active;
            r_hs1    <= w_hs_raw;
            r_vs1    <= w_vs_raw;
        end
    end

    // Scan from the back so the lowest-index opaque sprite wins.
    always_comb begin
        w_pix = bg_rgb;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_pix = spr_data[i*COLOR_W +: COLOR_W];
            end
        end
    end

    assign w_coll = w_opaque[0] ? (w_opaque & ~NUM_SPRITES'(1)) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb     <= '0;
            r_hs2     <= 1'b1;
            r_vs2     <= 1'b1;
            r_accum   <= '0;
            r_collide <= '0;
        end else if (w_pix_en) begin
            r_rgb <= r_active ? w_pix : '0;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            if (w_frame_start) begin
                r_collide <= r_accum;
                r_accum   <= w_coll;
            end else begin
                r_accum <= r_accum | w_coll;
            end
        end
    end

    assign hcount      = w_hcount;
    assign vcount      = w_vcount;
    assign spr_addr    = r_addr;
    assign hs          = r_hs2;
    assign vs          = r_vs2;
    assign rgb         = r_rgb;
    assign frame_start = w_frame_start;
    assign collide     = r_collide;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for the sprite compositor on a shrunken raster (40x24 pixels,
// 2 clocks per pixel, 4x4 sprites) so several frames fit in a short run.
module tb_vga_sprite_compositor;

    localparam int NS  = 7;
    localparam int SS  = 4;
    localparam int CW  = 8;
    localparam int CD  = 2;
    localparam int HT  = 40;
    localparam int HSY = 4;
    localparam int HST = 8;
    localparam int HA  = 24;
    localparam int VT  = 24;
    localparam int VSY = 2;
    localparam int VST = 3;
    localparam int VA  = 16;
    localparam int IW  = 3;
    localparam int AW  = 4;
    localparam logic [7:0] BG = 8'h49;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_we = 1'b0;
    logic [IW-1:0]     cfg_idx = '0;
    logic [9:0]        cfg_x = '0;
    logic [9:0]        cfg_y = '0;
    logic              cfg_vis = 1'b0;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic [CW-1:0]     bg_rgb;
    logic [NS*AW-1:0]  spr_addr;
    logic [NS*CW-1:0]  spr_data;
    logic              hs;
    logic              vs;
    logic [CW-1:0]     rgb;
    logic              frame_start;
    logic [NS-1:0]     collide;

    logic [7:0] rom_val [NS];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign bg_rgb = BG;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) spr_data[i*CW +: CW] <= rom_val[i];
    end

    vga_sprite_compositor #(
        .NUM_SPRITES (NS),
        .SPR_SIZE    (SS),
        .COLOR_W     (CW),
        .TRANSPARENT (8'hFF),
        .CLK_DIV     (CD),
        .H_TOTAL     (HT),
        .H_SYNC      (HSY),
        .H_START     (HST),
        .H_ACTIVE    (HA),
        .V_TOTAL     (VT),
        .V_SYNC      (VSY),
        .V_START     (VST),
        .V_ACTIVE    (VA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .cfg_vis     (cfg_vis),
        .hcount      (hcount),
        .vcount      (vcount),
        .bg_rgb      (bg_rgb),
        .spr_addr    (spr_addr),
        .spr_data    (spr_data),
        .hs          (hs),
        .vs          (vs),
        .rgb         (rgb),
        .frame_start (frame_start),
        .collide     (collide)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_coord(input int h, input int v);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 4000 && !found; n++) begin
            @(negedge clk);
            if (hcount == 10'(h) && vcount == 10'(v)) found = 1'b1;
        end
        chk("coord_reached", 32'(found), 32'd1);
    endtask

    task automatic wait_fs();
        logic found;
        found = 1'b0;
        for (int n = 0; n < 4000 && !found; n++) begin
            @(negedge clk);
            if (frame_start) found = 1'b1;
        end
        chk("frame_start_seen", 32'(found), 32'd1);
    endtask

    // rgb for pixel (h,v) is on the output while hcount shows h+2.
    task automatic px(input string tag, input int h, input int v, input logic [7:0] exp);
        wait_coord(h + 2, v);
        chk(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic write_cfg(input int idx, input int x, input int y, input logic vis);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_idx = IW'(idx);
        cfg_x   = 10'(x);
        cfg_y   = 10'(y);
        cfg_vis = vis;
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    task automatic write_at_fs(input int idx, input int x, input int y, input logic vis);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 4000 && !found; n++) begin
            @(negedge clk);
            if (frame_start) found = 1'b1;
        end
        chk("fs_for_write", 32'(found), 32'd1);
        cfg_we  = 1'b1;
        cfg_idx = IW'(idx);
        cfg_x   = 10'(x);
        cfg_y   = 10'(y);
        cfg_vis = vis;
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    initial begin
        int hs_fall_t, hs_per, hs_low, vs_fall_t, vs_per, vs_low;
        int fs_t, fs_int, fs_hi, fs_rise, n_fs;
        logic hs_prev, vs_prev, fs_prev, got;

        for (int i = 0; i < NS; i++) rom_val[i] = 8'h00;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_rgb", 32'(rgb), 32'h0);
        chk("rst_hs", 32'(hs), 32'd1);
        chk("rst_vs", 32'(vs), 32'd1);
        chk("rst_collide", 32'(collide), 32'h0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_hcount", 32'(hcount), 32'd0);
        chk("rst_vcount", 32'(vcount), 32'd0);
        chk("rst_addr", 32'(spr_addr), 32'h0);
        rst = 1'b1;

        // Sync timing over two frames, no sprites
        hs_fall_t = -1; hs_per = -1; hs_low = -1;
        vs_fall_t = -1; vs_per = -1; vs_low = -1;
        fs_t = -1; fs_int = -1; fs_hi = 0; fs_rise = 0;
        hs_prev = hs; vs_prev = vs; fs_prev = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (hs_prev && !hs) begin
                if (hs_fall_t >= 0 && hs_per < 0) hs_per = c - hs_fall_t;
                hs_fall_t = c;
            end
            if (!hs_prev && hs && hs_fall_t >= 0 && hs_low < 0) hs_low = c - hs_fall_t;
            if (vs_prev && !vs) begin
                if (vs_fall_t >= 0 && vs_per < 0) vs_per = c - vs_fall_t;
                vs_fall_t = c;
            end
            if (!vs_prev && vs && vs_fall_t >= 0 && vs_low < 0) vs_low = c - vs_fall_t;
            if (frame_start) fs_hi++;
            if (frame_start && !fs_prev) begin
                fs_rise++;
                if (fs_t >= 0 && fs_int < 0) fs_int = c - fs_t;
                fs_t = c;
            end
            hs_prev = hs; vs_prev = vs; fs_prev = frame_start;
        end
        chk("hs_period_clks", 32'(hs_per), 32'(HT * CD));
        chk("hs_low_clks", 32'(hs_low), 32'(HSY * CD));
        chk("vs_period_clks", 32'(vs_per), 32'(HT * VT * CD));
        chk("vs_low_clks", 32'(vs_low), 32'(HT * VSY * CD));
        chk("fs_interval_clks", 32'(fs_int), 32'(HT * VT * CD));
        chk("fs_pulses", 32'(fs_rise), 32'd3);
        chk("fs_one_clk_wide", 32'(fs_hi), 32'(fs_rise));

        // Single sprite 1 at (16,6)
        rom_val[1] = 8'h1C;
        write_cfg(1, 16, 6, 1'b1);
        wait_fs();
        px("s1_above", 12, 5, BG);
        px("s1_blank", 4, 6, 8'h00);
        px("s1_left", 15, 6, BG);
        px("s1_tl", 16, 6, 8'h1C);
        wait_coord(18, 7);
        chk("s1_addr", 32'(spr_addr[1*AW +: AW]), 32'd5);
        px("s1_br", 19, 9, 8'h1C);
        px("s1_right", 20, 9, BG);
        px("s1_below", 16, 10, BG);

        // Sprites 0 and 2 overlapping, priority and collision
        write_cfg(1, 16, 6, 1'b0);
        rom_val[0] = 8'hE0;
        rom_val[2] = 8'h03;
        write_cfg(0, 24, 12, 1'b1);
        write_cfg(2, 24, 12, 1'b1);
        write_cfg(7, 16, 6, 1'b1);
        wait_fs();
        px("s1_off_badidx", 16, 6, BG);
        px("ovl_prio_a", 25, 13, 8'hE0);
        px("ovl_prio_b", 27, 15, 8'hE0);
        wait_fs();
        @(negedge clk);
        chk("collide_02", 32'(collide), 32'h04);
        rom_val[0] = 8'hFF;
        px("ovl_transparent", 25, 13, 8'h03);
        wait_fs();
        @(negedge clk);
        chk("collide_none", 32'(collide), 32'h00);
        rom_val[0] = 8'hE0;

        // Double-buffered position of sprite 3
        rom_val[3] = 8'h92;
        write_cfg(3, 10, 4, 1'b1);
        wait_fs();
        px("s3_old_pos", 10, 4, 8'h92);
        write_cfg(3, 20, 4, 1'b1);
        px("s3_new_not_yet", 20, 4, BG);
        px("s3_old_still", 11, 5, 8'h92);
        wait_fs();
        px("s3_old_gone", 10, 4, BG);
        px("s3_new_pos", 20, 4, 8'h92);
        write_at_fs(3, 28, 4, 1'b1);
        px("s3_fs_write_old", 20, 4, BG);
        px("s3_fs_write_new", 28, 4, 8'h92);

        // Sprite 4 straddling the 10-bit column wrap
        write_cfg(3, 28, 4, 1'b0);
        rom_val[4] = 8'h6D;
        write_cfg(4, 1022, 4, 1'b1);
        wait_fs();
        wait_coord(1, 4);
        chk("wrap_addr_h0", 32'(spr_addr[4*AW +: AW]), 32'h0);
        wait_coord(2, 4);
        chk("wrap_addr_h1", 32'(spr_addr[4*AW +: AW]), 32'h0);
        px("wrap_no_hit", 8, 4, BG);

        // Reset asserted mid-line while both syncs are low
        wait_coord(3, 1);
        chk("pre_rst_hs", 32'(hs), 32'd0);
        chk("pre_rst_vs", 32'(vs), 32'd0);
        chk("pre_rst_collide", 32'(collide), 32'h04);
        rst = 1'b0;
        #1;
        chk("mid_rst_rgb", 32'(rgb), 32'h0);
        chk("mid_rst_hs", 32'(hs), 32'd1);
        chk("mid_rst_vs", 32'(vs), 32'd1);
        chk("mid_rst_collide", 32'(collide), 32'h0);
        chk("mid_rst_hcount", 32'(hcount), 32'd0);
        chk("mid_rst_vcount", 32'(vcount), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        n_fs = -1;
        got = 1'b0;
        for (int n = 1; n <= 10 && !got; n++) begin
            @(negedge clk);
            if (frame_start) begin
                got = 1'b1;
                n_fs = n;
            end
        end
        chk("post_rst_fs_delay", 32'(n_fs), 32'(CD - 1));
        chk("post_rst_fs_hcount", 32'(hcount), 32'd0);
        chk("post_rst_fs_vcount", 32'(vcount), 32'd0);
        px("post_rst_cfg_clear", 25, 13, BG);
        wait_fs();
        @(negedge clk);
        chk("post_rst_collide", 32'(collide), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
